// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with 8-word lines and an uncached bypass path.
// Define ICACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counter outputs.
module instr_cache #(
  parameter int LINE_OFFSET_WIDTH = 5,
  parameter int INDEX_WIDTH       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_ena,
  input  logic        flush,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic [31:0] s_rdata,
  output logic        s_rvalid,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  input  logic        m_rlast,
  output logic        m_rready
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int WORD_W  = LINE_OFFSET_WIDTH - 2;
  localparam int WORDS   = 1 << WORD_W;
  localparam int LINES   = 1 << INDEX_WIDTH;
  localparam int TAG_LSB = LINE_OFFSET_WIDTH + INDEX_WIDTH;
  localparam int TAG_W   = 32 - TAG_LSB;

  typedef enum logic [1:0] {IDLE, MREQ, REFILL, RESP} state_t;

  state_t                   state_q, state_d;
  logic [TAG_W-1:0]         req_tag_q, req_tag_d;
  logic [INDEX_WIDTH-1:0]   req_idx_q, req_idx_d;
  logic [WORD_W-1:0]        req_word_q, req_word_d;
  logic                     uncached_q, uncached_d;
  logic                     cancel_q, cancel_d;
  logic [WORD_W:0]          beat_q, beat_d;
  logic [31:0]              fill_data_q, fill_data_d;
  logic [31:0]              s_rdata_q, s_rdata_d;
  logic                     resp_q, resp_d;
  logic [31:0]              m_araddr_q, m_araddr_d;
  logic                     m_arvalid_q, m_arvalid_d;
  logic                     m_rready_q, m_rready_d;
  logic [LINES-1:0]         valid_q, valid_d;

  logic [31:0]              data_mem [LINES*WORDS];
  logic [TAG_W-1:0]         tag_mem  [LINES];

  logic                     fill_we;
  logic                     tag_we;
  logic                     hit_inc;
  logic                     miss_inc;

  logic [TAG_W-1:0]         in_tag;
  logic [INDEX_WIDTH-1:0]   in_idx;
  logic [WORD_W-1:0]        in_word;
  logic                     lookup_hit;
  logic [31:0]              lookup_word;

  assign in_tag      = s_araddr[31:TAG_LSB];
  assign in_idx      = s_araddr[TAG_LSB-1:LINE_OFFSET_WIDTH];
  assign in_word     = s_araddr[LINE_OFFSET_WIDTH-1:2];
  assign lookup_hit  = valid_q[in_idx] && (tag_mem[in_idx] == in_tag);
  assign lookup_word = data_mem[{in_idx, in_word}];

  always_comb begin
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    req_word_d  = req_word_q;
    uncached_d  = uncached_q;
    cancel_d    = cancel_q;
    beat_d      = beat_q;
    fill_data_d = fill_data_q;
    s_rdata_d   = s_rdata_q;
    resp_d      = 1'b0;
    m_araddr_d  = m_araddr_q;
    m_arvalid_d = m_arvalid_q;
    m_rready_d  = m_rready_q;
    valid_d     = valid_q;
    fill_we     = 1'b0;
    tag_we      = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_arvalid && !flush) begin
          req_tag_d  = in_tag;
          req_idx_d  = in_idx;
          req_word_d = in_word;
          uncached_d = !cache_ena;
          cancel_d   = 1'b0;
          beat_d     = '0;
          if (cache_ena && lookup_hit) begin
            state_d   = RESP;
            resp_d    = 1'b1;
            s_rdata_d = lookup_word;
            hit_inc   = 1'b1;
          end else begin
            state_d     = MREQ;
            m_arvalid_d = 1'b1;
            m_araddr_d  = cache_ena ? {s_araddr[31:LINE_OFFSET_WIDTH], {LINE_OFFSET_WIDTH{1'b0}}}
                                    : s_araddr;
            miss_inc    = cache_ena;
          end
        end
      end

      MREQ: begin
        if (flush) cancel_d = 1'b1;
        if (m_arready) begin
          m_arvalid_d = 1'b0;
          m_rready_d  = 1'b1;
          state_d     = REFILL;
        end
      end

      // Beats past the line length are accepted but dropped; the burst always runs to rlast.
      REFILL: begin
        if (flush) cancel_d = 1'b1;
        if (m_rvalid) begin
          if (!beat_q[WORD_W]) begin
            beat_d  = beat_q + 1'b1;
            fill_we = !uncached_q;
            if (uncached_q ? (beat_q == '0) : (beat_q[WORD_W-1:0] == req_word_q))
              fill_data_d = m_rdata;
          end
          if (m_rlast) begin
            m_rready_d = 1'b0;
            if (!uncached_q) begin
              tag_we             = 1'b1;
              valid_d[req_idx_q] = 1'b1;
            end
            if (cancel_q || flush) begin
              state_d = IDLE;
            end else begin
              state_d   = RESP;
              resp_d    = 1'b1;
              s_rdata_d = fill_data_d;
            end
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_word_q  <= '0;
      uncached_q  <= 1'b0;
      cancel_q    <= 1'b0;
      beat_q      <= '0;
      fill_data_q <= '0;
      s_rdata_q   <= '0;
      resp_q      <= 1'b0;
      m_araddr_q  <= '0;
      m_arvalid_q <= 1'b0;
      m_rready_q  <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      req_word_q  <= req_word_d;
      uncached_q  <= uncached_d;
      cancel_q    <= cancel_d;
      beat_q      <= beat_d;
      fill_data_q <= fill_data_d;
      s_rdata_q   <= s_rdata_d;
      resp_q      <= resp_d;
      m_araddr_q  <= m_araddr_d;
      m_arvalid_q <= m_arvalid_d;
      m_rready_q  <= m_rready_d;
      valid_q     <= valid_d;
    end
  end

  // Line storage carries no reset; the valid bits alone decide whether contents are usable.
  always_ff @(posedge clk) begin
    if (fill_we) data_mem[{req_idx_q, beat_q[WORD_W-1:0]}] <= m_rdata;
    if (tag_we)  tag_mem[req_idx_q] <= req_tag_q;
  end

  assign s_rdata   = s_rdata_q;
  assign s_rvalid  = resp_q && !flush;
  assign m_araddr  = m_araddr_q;
  assign m_arvalid = m_arvalid_q;
  assign m_rready  = m_rready_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'd0, hit_inc};
    miss_cnt_d = miss_cnt_q + {31'd0, miss_inc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = hit_inc ^ miss_inc;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard testbench for instr_cache: a burst memory model, a directed request
// sequence pushing expected responses, and a monitor that pops and compares them.
module tb_instr_cache;

   logic        clk;
   logic        rst;
   logic        cacheEna;
   logic        flush;
   logic [31:0] sAraddr;
   logic        sArvalid;
   logic [31:0] sRdata;
   logic        sRvalid;
   logic [31:0] mAraddr;
   logic        mArvalid;
   logic        mArready;
   logic [31:0] mRdata;
   logic        mRvalid;
   logic        mRlast;
   logic        mRready;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hitCnt;
   logic [31:0] missCnt;
`endif

   typedef struct {
      logic [31:0] data;
      int          reqCycle;
      int          lat;
   } exp_t;

   exp_t        expQ[$];
   int          cycleCount;
   int          compared;
   int          mismatched;
   logic [31:0] lastArAddr;
   int          arCount;
   int          arBefore;

   instr_cache dut (
      .clk       (clk),
      .rst       (rst),
      .cache_ena (cacheEna),
      .flush     (flush),
      .s_araddr  (sAraddr),
      .s_arvalid (sArvalid),
      .s_rdata   (sRdata),
      .s_rvalid  (sRvalid),
      .m_araddr  (mAraddr),
      .m_arvalid (mArvalid),
      .m_arready (mArready),
      .m_rdata   (mRdata),
      .m_rvalid  (mRvalid),
      .m_rlast   (mRlast),
      .m_rready  (mRready)
`ifdef ICACHE_PERF_CNT_EN
      ,
      .hit_cnt   (hitCnt),
      .miss_cnt  (missCnt)
`endif
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to measure response latency from the request cycle.
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Single comparison helper shared by stimulus and monitor; every call counts once.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Memory model: accepts one address per idle period, then streams nine beats
   // whose data is the line base with the beat index in the low byte bits.
   initial begin : memModel
      logic [31:0] burstAddr;
      mArready = 1'b0;
      mRvalid  = 1'b0;
      mRlast   = 1'b0;
      mRdata   = 32'd0;
      lastArAddr = 32'd0;
      arCount  = 0;
      forever begin
         @(negedge clk);
         if (mArvalid && !rst) begin
            mArready   = 1'b1;
            burstAddr  = mAraddr;
            lastArAddr = mAraddr;
            arCount++;
            @(negedge clk);
            mArready = 1'b0;
            for (int beat = 0; beat < 9; beat++) begin
               logic [4:0] low;
               low     = 5'(beat * 4);
               mRvalid = 1'b1;
               mRdata  = {burstAddr[31:5], low};
               mRlast  = (beat == 8);
               @(negedge clk);
            end
            mRvalid = 1'b0;
            mRlast  = 1'b0;
         end
      end
   end

   // Monitor: every s_rvalid pulse must match the oldest expected response.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && sRvalid) begin
            if (expQ.size() == 0) begin
               checkOutput("spurious_rvalid", {31'd0, sRvalid}, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("rdata", sRdata, e.data);
               checkOutput("latency", 32'(cycleCount - e.reqCycle), 32'(e.lat));
            end
         end
      end
   end

   // Issues one single-cycle request; when a response is expected it is queued and
   // the task waits (bounded) for the monitor to consume it before settling.
   task automatic applyStimulus(input logic [31:0] addr, input logic ena, input logic fl,
                                input bit expResp, input logic [31:0] expData, input int expLat,
                                input int settle);
      exp_t e;
      int   waited;
      @(negedge clk);
      sAraddr  = addr;
      cacheEna = ena;
      flush    = fl;
      sArvalid = 1'b1;
      if (expResp) begin
         e.data     = expData;
         e.reqCycle = cycleCount;
         e.lat      = expLat;
         expQ.push_back(e);
      end
      @(negedge clk);
      sArvalid = 1'b0;
      flush    = 1'b0;
      waited   = 0;
      while (expQ.size() != 0 && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      if (expQ.size() != 0) begin
         checkOutput("response_timeout", 32'(expQ.size()), 32'd0);
         expQ.delete();
      end
      repeat (settle) @(negedge clk);
   endtask

   // Directed sequence with hand-computed data and latencies (hit 1, miss 11 cycles).
   initial begin : stimulus
      cycleCount = 0;
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      cacheEna   = 1'b1;
      flush      = 1'b0;
      sAraddr    = 32'd0;
      sArvalid   = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_s_rvalid", {31'd0, sRvalid}, 32'd0);
      checkOutput("reset_s_rdata", sRdata, 32'd0);
      checkOutput("reset_m_arvalid", {31'd0, mArvalid}, 32'd0);
      checkOutput("reset_m_rready", {31'd0, mRready}, 32'd0);
      checkOutput("reset_m_araddr", mAraddr, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      applyStimulus(32'hf000_0000, 1'b1, 1'b0, 1'b1, 32'hf000_0000, 11, 2);
      checkOutput("cold_m_araddr", lastArAddr, 32'hf000_0000);
      checkOutput("cold_ar_count", 32'(arCount), 32'd1);
      applyStimulus(32'hf000_0004, 1'b1, 1'b0, 1'b1, 32'hf000_0004, 1, 0);
      applyStimulus(32'hf000_0008, 1'b1, 1'b0, 1'b1, 32'hf000_0008, 1, 0);
      applyStimulus(32'hf000_000c, 1'b1, 1'b0, 1'b1, 32'hf000_000c, 1, 0);
      checkOutput("hits_no_fetch", 32'(arCount), 32'd1);

      applyStimulus(32'hf000_0040, 1'b1, 1'b0, 1'b1, 32'hf000_0040, 11, 2);
      checkOutput("idx2_m_araddr", lastArAddr, 32'hf000_0040);
      applyStimulus(32'hf000_0044, 1'b1, 1'b0, 1'b1, 32'hf000_0044, 1, 0);
      applyStimulus(32'hf000_0000, 1'b1, 1'b0, 1'b1, 32'hf000_0000, 1, 0);

      arBefore = arCount;
      applyStimulus(32'hffff_ffff, 1'b1, 1'b1, 1'b0, 32'd0, 0, 15);
      checkOutput("idle_flush_no_fetch", 32'(arCount - arBefore), 32'd0);
      applyStimulus(32'hf000_0014, 1'b1, 1'b0, 1'b1, 32'hf000_0014, 1, 0);

      applyStimulus(32'h0000_0018, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 11, 2);
      checkOutput("uncached_m_araddr", lastArAddr, 32'h0000_0018);
      arBefore = arCount;
      applyStimulus(32'h0000_0018, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 11, 2);
      checkOutput("uncached_refetch", 32'(arCount - arBefore), 32'd1);

      // Flush while the burst is streaming: no response, but the line still fills.
      applyStimulus(32'hf000_0100, 1'b1, 1'b0, 1'b0, 32'd0, 0, 0);
      repeat (3) @(negedge clk);
      checkOutput("refill_m_rready", {31'd0, mRready}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("flushed_m_araddr", lastArAddr, 32'hf000_0100);
      checkOutput("flushed_rdata_hold", sRdata, 32'h0000_0000);
      applyStimulus(32'hf000_0104, 1'b1, 1'b0, 1'b1, 32'hf000_0104, 1, 0);
      applyStimulus(32'hf000_0200, 1'b1, 1'b0, 1'b1, 32'hf000_0200, 11, 4);
      checkOutput("rdata_hold", sRdata, 32'hf000_0200);

      // Reset in the middle of a refill aborts it and invalidates every line.
      applyStimulus(32'hf000_0300, 1'b1, 1'b0, 1'b0, 32'd0, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midreset_m_rready", {31'd0, mRready}, 32'd0);
      checkOutput("midreset_s_rdata", sRdata, 32'd0);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      applyStimulus(32'hf000_0000, 1'b1, 1'b0, 1'b1, 32'hf000_0000, 11, 3);

      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Hard time limit so the run always ends even if the sequence stalls.
   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
